mix_columns_iter: RTL and testbench

MIX_COLUMNS_ITER -- requirements
Module: mix_columns_iter

---
 rtl/mix_columns_iter.sv | 151 +++++++++++++++
 tb/tb_mix_columns_iter.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/mix_columns_iter.sv
// AES MixColumns / InvMixColumns, one column per cycle.
// Handshaked in and out; bypass passes the state straight through.
module mix_columns_iter (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_text,
    input  logic         mode,
    input  logic         bypass,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_text
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t       state_q, state_d;
    logic [1:0]   cnt_q, cnt_d;
    logic [127:0] text_q, text_d;
    logic [127:0] out_q, out_d;
    logic         mode_q, mode_d;
    logic         in_ready_q, in_ready_d;
    logic         out_valid_q, out_valid_d;
    logic [31:0]  col_in, col_out;

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] b,
                                        input logic [3:0] k);
        logic [7:0] a;
        logic [7:0] p;
        a = b;
        p = '0;
        for (int i = 0; i < 4; i++) begin
            if (k[i]) p = p ^ a;
            a = xt(a);
        end
        return p;
    endfunction

    // Row r uses the coefficient row rotated right by r bytes.
    function automatic logic [31:0] mix(input logic [31:0] c,
                                        input logic       inv);
        logic [7:0] s [4];
        logic [7:0] r [4];
        logic [3:0] k [4];
        logic [1:0] idx;
        s[0] = c[31:24];
        s[1] = c[23:16];
        s[2] = c[15:8];
        s[3] = c[7:0];
        if (inv) begin
            k[0] = 4'd14; k[1] = 4'd11; k[2] = 4'd13; k[3] = 4'd9;
        end else begin
            k[0] = 4'd2;  k[1] = 4'd3;  k[2] = 4'd1;  k[3] = 4'd1;
        end
        for (int row = 0; row < 4; row++) begin
            r[row] = '0;
            for (int j = 0; j < 4; j++) begin
                idx = 2'(j - row);
                r[row] = r[row] ^ gmul(s[j], k[idx]);
            end
        end
        return {r[0], r[1], r[2], r[3]};
    endfunction

    always_comb begin
        col_in = text_q[127:96];
        unique case (cnt_q)
            2'd0: col_in = text_q[127:96];
            2'd1: col_in = text_q[95:64];
            2'd2: col_in = text_q[63:32];
            2'd3: col_in = text_q[31:0];
            default: col_in = text_q[127:96];
        endcase
    end

    assign col_out = mix(col_in, mode_q);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        text_d  = text_q;
        mode_d  = mode_q;
        out_d   = out_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    text_d = in_text;
                    mode_d = mode;
                    cnt_d  = 2'd0;
                    if (bypass) begin
                        out_d   = in_text;
                        state_d = DONE;
                    end else begin
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                unique case (cnt_q)
                    2'd0: out_d[127:96] = col_out;
                    2'd1: out_d[95:64]  = col_out;
                    2'd2: out_d[63:32]  = col_out;
                    2'd3: out_d[31:0]   = col_out;
                    default: out_d = out_q;
                endcase
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'd3) state_d = DONE;
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= 2'd0;
            text_q      <= '0;
            mode_q      <= 1'b0;
            out_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            text_q      <= text_d;
            mode_q      <= mode_d;
            out_q       <= out_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_text  = out_q;

endmodule

// File: tb/tb_mix_columns_iter.sv
// Directed bench for mix_columns_iter: known AES vectors,
// latency, bypass with backpressure, reset abort, back-to-back.
module tb_mix_columns_iter;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_text;
    logic         mode;
    logic         bypass;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_text;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    mix_columns_iter dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_text   (in_text),
        .mode      (mode),
        .bypass    (bypass),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_text  (out_text)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Carry-less product then reduction by x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gf_ref(input logic [7:0] a,
                                          input logic [7:0] b);
        logic [14:0] p;
        p = '0;
        for (int i = 0; i < 8; i++)
            if (b[i]) p = p ^ (15'(a) << i);
        for (int i = 14; i >= 8; i--)
            if (p[i]) p = p ^ (15'h11b << (i - 8));
        return p[7:0];
    endfunction

    function automatic logic [127:0] mix_ref(input logic [127:0] t,
                                             input logic inv);
        logic [127:0] res;
        logic [7:0]   s [4];
        logic [7:0]   e [4];
        logic [7:0]   r;
        logic [31:0]  col;
        if (inv) begin
            e[0] = 8'd14; e[1] = 8'd11; e[2] = 8'd13; e[3] = 8'd9;
        end else begin
            e[0] = 8'd2;  e[1] = 8'd3;  e[2] = 8'd1;  e[3] = 8'd1;
        end
        res = '0;
        for (int c = 0; c < 4; c++) begin
            col = t[127 - 32*c -: 32];
            for (int j = 0; j < 4; j++) s[j] = col[31 - 8*j -: 8];
            for (int row = 0; row < 4; row++) begin
                r = '0;
                for (int j = 0; j < 4; j++)
                    r = r ^ gf_ref(s[j], e[(j - row + 4) % 4]);
                res[127 - 32*c - 8*row -: 8] = r;
            end
        end
        return res;
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (in_ready !== 1'b1 && n < 50) begin
            step;
            n++;
        end
        chk({tag, "_ready_wait"}, 128'(in_ready), 128'd1);
    endtask

    task automatic run_txn(input string tag, input logic [127:0] t,
                           input logic m, input logic [127:0] exp);
        int n;
        wait_ready(tag);
        in_valid = 1'b1;
        in_text  = t;
        mode     = m;
        bypass   = 1'b0;
        step;
        in_valid = 1'b0;
        in_text  = ~t;
        mode     = ~m;
        bypass   = 1'b1;
        chk({tag, "_busy_rdy"}, 128'(in_ready), 128'd0);
        n = 0;
        while (out_valid !== 1'b1 && n < 20) begin
            step;
            n++;
        end
        bypass = 1'b0;
        chk({tag, "_latency"}, 128'(n), 128'd4);
        chk({tag, "_data"}, out_text, exp);
        out_ready = 1'b1;
        step;
        out_ready = 1'b0;
        chk({tag, "_rel_rdy"}, 128'(in_ready), 128'd1);
        chk({tag, "_rel_vld"}, 128'(out_valid), 128'd0);
    endtask

    logic [127:0] enc_in, enc_out, col_in, col_out, byp, rnd;
    logic [127:0] b2b_in [3];
    logic         b2b_md [3];
    int           acc [3];
    int           n;

    initial begin
        enc_in  = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
        enc_out = 128'h046681e5e0cb199a48f8d37a2806264c;
        col_in  = 128'hdb135345f20a225c01010101c6c6c6c6;
        col_out = 128'h8e4da1bc9fdc589d01010101c6c6c6c6;
        byp     = 128'h00112233445566778899aabbccddeeff;
        rnd     = {$urandom, $urandom, $urandom, $urandom};

        rst = 1'b1; in_valid = 1'b0; in_text = '0;
        mode = 1'b0; bypass = 1'b0; out_ready = 1'b0;
        step;
        step;
        rst = 1'b0;
        chk("rst_rdy", 128'(in_ready), 128'd1);
        chk("rst_vld", 128'(out_valid), 128'd0);
        chk("rst_txt", out_text, 128'd0);

        run_txn("enc", enc_in, 1'b0, enc_out);
        run_txn("col_enc", col_in, 1'b0, col_out);
        run_txn("col_dec", col_out, 1'b1, col_in);
        run_txn("dec", enc_out, 1'b1, enc_in);
        run_txn("col_in_dec", col_in, 1'b1, mix_ref(col_in, 1'b1));
        run_txn("rnd_enc", rnd, 1'b0, mix_ref(rnd, 1'b0));
        run_txn("rnd_dec", rnd, 1'b1, mix_ref(rnd, 1'b1));

        wait_ready("byp");
        in_valid = 1'b1;
        in_text  = byp;
        bypass   = 1'b1;
        mode     = 1'b0;
        step;
        in_valid = 1'b0;
        in_text  = '0;
        chk("byp_vld", 128'(out_valid), 128'd1);
        chk("byp_txt", out_text, byp);
        for (int i = 0; i < 5; i++) begin
            in_valid = ((i % 2) == 0);
            in_text  = {$urandom, $urandom, $urandom, $urandom};
            step;
            chk("bp_txt", out_text, byp);
            chk("bp_rdy", 128'(in_ready), 128'd0);
            chk("bp_vld", 128'(out_valid), 128'd1);
        end
        in_valid  = 1'b0;
        bypass    = 1'b0;
        out_ready = 1'b1;
        step;
        out_ready = 1'b0;
        chk("bp_rel_rdy", 128'(in_ready), 128'd1);
        chk("bp_rel_vld", 128'(out_valid), 128'd0);
        step;
        chk("bp_noq_rdy", 128'(in_ready), 128'd1);
        chk("bp_noq_txt", out_text, byp);

        wait_ready("abort");
        in_valid = 1'b1;
        in_text  = enc_in;
        mode     = 1'b0;
        step;
        in_valid = 1'b0;
        step;
        rst = 1'b1;
        step;
        rst = 1'b0;
        chk("abort_vld", 128'(out_valid), 128'd0);
        chk("abort_txt", out_text, 128'd0);
        chk("abort_rdy", 128'(in_ready), 128'd1);
        step;
        chk("abort_vld2", 128'(out_valid), 128'd0);
        run_txn("post_abort", enc_in, 1'b0, enc_out);

        b2b_in[0] = enc_in;  b2b_md[0] = 1'b0;
        b2b_in[1] = enc_out; b2b_md[1] = 1'b1;
        b2b_in[2] = rnd;     b2b_md[2] = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wait_ready("b2b");
            in_valid = 1'b1;
            in_text  = b2b_in[k];
            mode     = b2b_md[k];
            step;
            acc[k]   = cyc;
            in_valid = 1'b0;
            n = 0;
            while (out_valid !== 1'b1 && n < 20) begin
                step;
                n++;
            end
            chk("b2b_lat", 128'(n), 128'd4);
            chk("b2b_data", out_text, mix_ref(b2b_in[k], b2b_md[k]));
        end
        out_ready = 1'b0;
        chk("b2b_gap01", 128'(acc[1] - acc[0]), 128'd6);
        chk("b2b_gap12", 128'(acc[2] - acc[1]), 128'd6);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
